// File: rtl/seq_barrel_shifter.sv
// Multi-cycle barrel shifter (SLL/SRL/SRA/ROR) resolving BITS_PER_CYCLE shift-amount bits
// per clock through logarithmic stages, with valid/ready handshakes on both sides.
module seq_barrel_shifter #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned SHAMT_W        = 5,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy
);

  localparam int unsigned Lat = (SHAMT_W + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  localparam int unsigned KW  = (Lat > 1) ? $clog2(Lat) : 1;
  localparam logic [KW-1:0] KLast = KW'(Lat - 1);

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;
  localparam logic [1:0] OpRor = 2'b11;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [1:0]         op_q, op_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic [WIDTH-1:0]   stage_val;

  // One log stage: shift v by s in the given mode; SRA fills with the sign latched at accept.
  function automatic logic [WIDTH-1:0] shift_stage(input logic [1:0]       mode,
                                                   input logic             sign,
                                                   input logic [WIDTH-1:0] v,
                                                   input int unsigned      s);
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] r;
    fill = sign ? ~({WIDTH{1'b1}} >> s) : '0;
    r    = v;
    unique case (mode)
      OpSll:   r = v << s;
      OpSrl:   r = v >> s;
      OpSra:   r = (v >> s) | fill;
      OpRor:   r = (v >> s) | (v << (WIDTH - s));
      default: r = v;
    endcase
    return r;
  endfunction

  // Only the stages belonging to the current slot k are applied this cycle.
  always_comb begin
    stage_val = work_q;
    for (int j = 0; j < int'(SHAMT_W); j++) begin
      if ((k_q == KW'(j / int'(BITS_PER_CYCLE))) &&
          ((shamt_q & (SHAMT_W'(1) << j)) != '0)) begin
        stage_val = shift_stage(op_q, sign_q, stage_val, 1 << j);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    op_d       = op_q;
    shamt_d    = shamt_q;
    sign_d     = sign_q;
    work_d     = work_q;
    data_out_d = data_out_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d    = op;
          shamt_d = shamt;
          sign_d  = data_in[WIDTH-1];
          work_d  = data_in;
          k_d     = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        work_d = stage_val;
        k_d    = k_q + 1'b1;
        if (k_q == KLast) begin
          k_d        = '0;
          data_out_d = stage_val;
          state_d    = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      k_q        <= '0;
      op_q       <= '0;
      shamt_q    <= '0;
      sign_q     <= 1'b0;
      work_q     <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      op_q       <= op_d;
      shamt_q    <= shamt_d;
      sign_q     <= sign_d;
      work_q     <= work_d;
      data_out_q <= data_out_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && !reset;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_seq_barrel_shifter.sv
// Bench for seq_barrel_shifter: three instances (1, 2 and 5 bits per cycle) checked against
// an arithmetic reference model with directed and random requests.
module tb_seq_barrel_shifter;

  logic clock = 1'b0;
  logic reset;
  logic [2:0]       iv, irdy, ov, ordy, bsy;
  logic [2:0][1:0]  opv;
  logic [2:0][4:0]  shv;
  logic [2:0][31:0] dv, dov;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  seq_barrel_shifter #(.WIDTH(32), .SHAMT_W(5), .BITS_PER_CYCLE(1)) u_b1 (
    .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(irdy[0]), .op(opv[0]),
    .shamt(shv[0]), .data_in(dv[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .data_out(dov[0]), .busy(bsy[0])
  );
  seq_barrel_shifter #(.WIDTH(32), .SHAMT_W(5), .BITS_PER_CYCLE(2)) u_b2 (
    .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(irdy[1]), .op(opv[1]),
    .shamt(shv[1]), .data_in(dv[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .data_out(dov[1]), .busy(bsy[1])
  );
  seq_barrel_shifter #(.WIDTH(32), .SHAMT_W(5), .BITS_PER_CYCLE(5)) u_b5 (
    .clock(clock), .reset(reset), .in_valid(iv[2]), .in_ready(irdy[2]), .op(opv[2]),
    .shamt(shv[2]), .data_in(dv[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .data_out(dov[2]), .busy(bsy[2])
  );

  function automatic int exp_lat(input int idx);
    case (idx)
      0:       return 5;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] model(input logic [1:0] o, input logic [4:0] s,
                                        input logic [31:0] d);
    logic [63:0] w;
    case (o)
      2'd0:    return d << s;
      2'd1:    return d >> s;
      2'd2:    return 32'($signed(d) >>> s);
      default: begin
        w = {d, d} >> s;
        return w[31:0];
      end
    endcase
  endfunction

  // Issue one request, measure accept-to-valid latency, then complete the transfer after
  // bp cycles of backpressure. lat is -1 when a bounded wait expires.
  task automatic run_op(input int idx, input logic [1:0] o, input logic [4:0] s,
                        input logic [31:0] d, input int bp, output int lat,
                        output logic [31:0] res, output logic post_valid,
                        output logic post_ready);
    int w;
    lat        = -1;
    res        = '0;
    post_valid = 1'b1;
    post_ready = 1'b0;
    @(negedge clock);
    w = 0;
    while (!irdy[idx] && w < 50) begin
      @(negedge clock);
      w++;
    end
    if (!irdy[idx]) return;
    iv[idx]  = 1'b1;
    opv[idx] = o;
    shv[idx] = s;
    dv[idx]  = d;
    @(posedge clock);
    #1;
    iv[idx] = 1'b0;
    w = 0;
    while (!ov[idx] && w < 50) begin
      @(posedge clock);
      #1;
      w++;
    end
    if (!ov[idx]) return;
    lat = w;
    res = dov[idx];
    repeat (bp) @(posedge clock);
    #1;
    ordy[idx] = 1'b1;
    @(posedge clock);
    #1;
    ordy[idx]  = 1'b0;
    post_valid = ov[idx];
    post_ready = irdy[idx];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks += 4;
      if (irdy[i] !== 1'b0) begin errors++; $display("FAIL rst_in_ready[%0d] got %b want 0", i, irdy[i]); end
      if (ov[i] !== 1'b0) begin errors++; $display("FAIL rst_out_valid[%0d] got %b want 0", i, ov[i]); end
      if (bsy[i] !== 1'b0) begin errors++; $display("FAIL rst_busy[%0d] got %b want 0", i, bsy[i]); end
      if (dov[i] !== 32'h0) begin errors++; $display("FAIL rst_data_out[%0d] got %h want 0", i, dov[i]); end
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (irdy[i] !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready[%0d] got %b want 1", i, irdy[i]); end
    end
  endtask

  task automatic test_directed();
    logic [1:0]  tops [6] = '{2'd2, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2};
    logic [4:0]  tsh  [6] = '{5'd2, 5'd2, 5'd31, 5'd4, 5'd8, 5'd31};
    logic [31:0] tin  [6] = '{32'h80000010, 32'h7FFFFFFC, 32'h80000000, 32'h000000FF,
                              32'h12345678, 32'h80000000};
    logic [31:0] texp [6] = '{32'hE0000004, 32'h1FFFFFFF, 32'h00000001, 32'h00000FF0,
                              32'h78123456, 32'hFFFFFFFF};
    int lat;
    logic [31:0] res;
    logic pv, pr;
    for (int i = 0; i < 3; i++) begin
      for (int t = 0; t < 6; t++) begin
        run_op(i, tops[t], tsh[t], tin[t], 0, lat, res, pv, pr);
        checks += 4;
        if (lat != exp_lat(i)) begin errors++; $display("FAIL dir_lat[%0d.%0d] got %0d want %0d", i, t, lat, exp_lat(i)); end
        if (res !== texp[t]) begin errors++; $display("FAIL dir_data[%0d.%0d] got %h want %h", i, t, res, texp[t]); end
        if (pv !== 1'b0) begin errors++; $display("FAIL dir_valid_drop[%0d.%0d] got %b want 0", i, t, pv); end
        if (pr !== 1'b1) begin errors++; $display("FAIL dir_ready_back[%0d.%0d] got %b want 1", i, t, pr); end
      end
    end
  endtask

  task automatic test_shamt_zero();
    int lat;
    logic [31:0] res;
    logic pv, pr;
    for (int o = 0; o < 4; o++) begin
      run_op(0, 2'(o), 5'd0, 32'hA5A5A5A5, 0, lat, res, pv, pr);
      checks += 2;
      if (lat != 5) begin errors++; $display("FAIL zero_lat[op%0d] got %0d want 5", o, lat); end
      if (res !== 32'hA5A5A5A5) begin errors++; $display("FAIL zero_data[op%0d] got %h want a5a5a5a5", o, res); end
    end
  endtask

  task automatic test_backpressure();
    int w;
    @(negedge clock);
    w = 0;
    while (!irdy[0] && w < 50) begin @(negedge clock); w++; end
    iv[0] = 1'b1; opv[0] = 2'd3; shv[0] = 5'd8; dv[0] = 32'h12345678;
    @(posedge clock);
    #1;
    iv[0] = 1'b0;
    w = 0;
    while (!ov[0] && w < 50) begin @(posedge clock); #1; w++; end
    checks++;
    if (!ov[0]) begin errors++; $display("FAIL bp_wait_valid got timeout want out_valid"); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      iv[0] = 1'b1; opv[0] = 2'd0; shv[0] = 5'd1; dv[0] = 32'hFFFFFFFF;
      @(posedge clock);
      #1;
      checks += 3;
      if (ov[0] !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", c, ov[0]); end
      if (dov[0] !== 32'h78123456) begin errors++; $display("FAIL bp_data[%0d] got %h want 78123456", c, dov[0]); end
      if (irdy[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", c, irdy[0]); end
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clock);
    #1;
    ordy[0] = 1'b0;
    checks += 4;
    if (ov[0] !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got %b want 0", ov[0]); end
    if (irdy[0] !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b want 1", irdy[0]); end
    if (bsy[0] !== 1'b0) begin errors++; $display("FAIL bp_busy got %b want 0", bsy[0]); end
    if (dov[0] !== 32'h78123456) begin errors++; $display("FAIL bp_data_held got %h want 78123456", dov[0]); end
  endtask

  task automatic test_reset_abort();
    int w;
    int lat;
    logic [31:0] res;
    logic pv, pr;
    @(negedge clock);
    w = 0;
    while (!irdy[0] && w < 50) begin @(negedge clock); w++; end
    iv[0] = 1'b1; opv[0] = 2'd1; shv[0] = 5'd3; dv[0] = 32'hF0F0F0F0;
    @(posedge clock);
    #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (bsy[0] !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", bsy[0]); end
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks += 4;
    if (ov[0] !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", ov[0]); end
    if (dov[0] !== 32'h0) begin errors++; $display("FAIL abort_data got %h want 0", dov[0]); end
    if (bsy[0] !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bsy[0]); end
    if (irdy[0] !== 1'b0) begin errors++; $display("FAIL abort_in_ready got %b want 0", irdy[0]); end
    reset = 1'b0;
    #1;
    checks++;
    if (irdy[0] !== 1'b1) begin errors++; $display("FAIL abort_ready_after got %b want 1", irdy[0]); end
    run_op(0, 2'd0, 5'd1, 32'h1, 0, lat, res, pv, pr);
    checks += 2;
    if (lat != 5) begin errors++; $display("FAIL abort_fresh_lat got %0d want 5", lat); end
    if (res !== 32'h2) begin errors++; $display("FAIL abort_fresh_data got %h want 2", res); end
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] res, d, e;
    logic [1:0] o;
    logic [4:0] s;
    logic pv, pr;
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 1000; n++) begin
        o = 2'($urandom_range(3));
        s = 5'($urandom_range(31));
        d = $urandom;
        e = model(o, s, d);
        run_op(i, o, s, d, int'($urandom_range(2)), lat, res, pv, pr);
        checks += 4;
        if (lat != exp_lat(i)) begin errors++; $display("FAIL rnd_lat[%0d.%0d] got %0d want %0d", i, n, lat, exp_lat(i)); end
        if (res !== e) begin errors++; $display("FAIL rnd_data[%0d.%0d] op%0d sh%0d in %h got %h want %h", i, n, o, s, d, res, e); end
        if (pv !== 1'b0) begin errors++; $display("FAIL rnd_valid_drop[%0d.%0d] got %b want 0", i, n, pv); end
        if (pr !== 1'b1) begin errors++; $display("FAIL rnd_ready_back[%0d.%0d] got %b want 1", i, n, pr); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    iv    = '0;
    ordy  = '0;
    opv   = '0;
    shv   = '0;
    dv    = '0;
    test_reset();
    test_directed();
    test_shamt_zero();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
